des_job_arbiter: RTL
====================

// Module: des_job_arbiter
// PURPOSE
//  Shares one non-pipelined DES core among N_REQ requesters. One job is in flight at a time.
//  Round-robin grant; issues the latched job to the core; waits for result, key-parity error or timeout.
//  Returns the result to the owning requester only. Sits between requester logic and the des top.
// PARAMETERS
//  N_REQ    4     number of requesters (2..8)
//  TIMEOUT  64    max cycles from core accept to result/err before the job is aborted (>=2)
// PORTS
//  clk_in                 in   1        clock; all logic on rising edge
//  rst_in                 in   1        reset, synchronous, active-high
//  req_valid_in           in   N_REQ    per-requester job valid
//  req_ready_out          out  N_REQ    per-requester job accept (one-hot or zero)
//  req_data_in            in   64*N_REQ data block, requester i at [64*i+:64]
//  req_key_in             in   64*N_REQ key incl. parity bits, requester i at [64*i+:64]
//  req_mode_in            in   N_REQ    encrypt/decrypt select, passed through unchanged
//  req_verify_in          in   N_REQ    key-parity check enable, passed through unchanged
//  rsp_valid_out          out  N_REQ    result valid to owner (one-hot or zero)
//  rsp_ready_in           in   N_REQ    per-requester result accept
//  rsp_data_out           out  64       shared result bus; qualified by rsp_valid_out[owner]
//  rsp_err_out            out  1        1 = key-parity error or timeout; rsp_data_out = 0 then
//  rsp_timeout_out        out  1        1 = error was a timeout
//  core_valid_out         out  1        to core encrypt_in_valid
//  core_ready_in          in   1        from core encrypt_ready
//  core_data_out/key_out  out  64 each  to core data_in / key_in
//  core_mode_out          out  1        to core mode_in
//  core_verify_out        out  1        to core verify_in
//  core_result_in         in   64       from core encrypt_out
//  core_result_valid_in   in   1        from core encrypt_out_valid
//  core_err_in            in   1        from core encrypt_err
//  busy_out               out  1        state != IDLE
//  stray_out              out  1        1-cycle pulse: core result/err seen outside WAIT (dropped)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; last_grant=N_REQ-1 (req 0 has first priority); timer=0.
//  IDLE: grant = first i with req_valid_in[i], searching from last_grant+1 with wrap.
//   req_ready_out[grant]=1 (combinational) only when a request is valid.
//   Core readiness does not gate grant. On accept, latch data/key/mode/verify/owner -> ISSUE.
//  ISSUE: core_valid_out=1 and core_*_out drive latched fields, held stable.
//   When core_ready_in=1: core accepts, timer=0 -> WAIT. Otherwise stay in ISSUE.
//   Next cycle core_valid_out=0.
//  WAIT: timer increments each cycle.
//   core_err_in=1: rsp_data=0, err=1, timeout=0 -> RESP. Err wins over a same-cycle result_valid.
//   Else core_result_valid_in=1: rsp_data=core_result_in, err=0 -> RESP.
//   Else timer==TIMEOUT-1: rsp_data=0, err=1, timeout=1 -> RESP.
//   A result arriving on the timeout cycle wins over the timeout.
//  RESP: rsp_valid_out[owner]=1; rsp_data/err/timeout held stable.
//   On rsp_ready_in[owner]: last_grant=owner -> IDLE. Other rsp_ready bits are ignored.
//   A new grant is possible in the cycle after return to IDLE (no IDLE bypass).
//  core_result_valid_in/core_err_in outside WAIT: dropped, stray_out pulses, state unchanged.
//  Latency: accept->core_valid 1 cycle; core result->rsp_valid 1 cycle.
//  Reset mid-job: abandon immediately, no response; the core's late output raises stray_out.
//  Fairness: a requester that keeps valid high waits at most N_REQ-1 jobs.
// STRUCTURE
//  des_arb_pkg: state_t enum {IDLE, ISSUE, WAIT, RESP}; localparam DES_BLK_W=64, DES_KEY_W=64.
//  Sub-module des_rr_arbiter (#N_REQ): combinational; req vector + last_grant ->
//   one-hot grant + index, any_req.
//  Top: FSM, job/result registers, timer sized $clog2(TIMEOUT).
// TESTING (bench wraps arbiter around des top, plus a stub core for error/timeout cases)
//  1 Req0 only, key 133457799BBCDFF1, data 0123456789ABCDEF, encrypt
//    -> rsp_valid_out=0001, rsp_data 85E813540F0AB405, err=0.
//  2 Req0..3 valid together, rsp_ready always 1 -> service order 0,1,2,3,0; each rsp only on its own bit.
//  3 Key 133457799BBCDFF0 (bad parity), verify=1
//    -> rsp_err_out=1, rsp_timeout_out=0, rsp_data 0; next job proceeds normally.
//  4 Stub never responds, TIMEOUT=64 -> rsp_valid 64 cycles after core accept with err=1, timeout=1;
//    later stub result -> stray_out 1 cycle, no rsp_valid.
//  5 Owner holds rsp_ready_in=0 for 10 cycles, other bits 1 -> rsp held stable, no new grant, no core_valid.
//  6 rst_in asserted in WAIT -> next cycle all outputs 0, IDLE;
//    first grant after release goes to req0 when all requests are valid.

Source files
------------

// File: rtl/des_arb_pkg.sv
// Shared types and widths for the DES job arbiter.
package des_arb_pkg;

  localparam int unsigned DES_BLK_W = 64;
  localparam int unsigned DES_KEY_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/des_rr_arbiter.sv
// Combinational round-robin pick: the first requester after last_i, with wrap.
module des_rr_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] last_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [$clog2(N_REQ)-1:0] idx_o,
  output logic                     any_o
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] cand;

  // Scan offsets 1..N_REQ from last_i; the first hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((32'(last_i) + k) % N_REQ);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/des_job_arbiter.sv
// Shares one non-pipelined DES core among N_REQ requesters, one job at a time.
module des_job_arbiter
  import des_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [N_REQ-1:0]           req_valid_in,
  output logic [N_REQ-1:0]           req_ready_out,
  input  logic [DES_BLK_W*N_REQ-1:0] req_data_in,
  input  logic [DES_KEY_W*N_REQ-1:0] req_key_in,
  input  logic [N_REQ-1:0]           req_mode_in,
  input  logic [N_REQ-1:0]           req_verify_in,
  output logic [N_REQ-1:0]           rsp_valid_out,
  input  logic [N_REQ-1:0]           rsp_ready_in,
  output logic [DES_BLK_W-1:0]       rsp_data_out,
  output logic                       rsp_err_out,
  output logic                       rsp_timeout_out,
  output logic                       core_valid_out,
  input  logic                       core_ready_in,
  output logic [DES_BLK_W-1:0]       core_data_out,
  output logic [DES_KEY_W-1:0]       core_key_out,
  output logic                       core_mode_out,
  output logic                       core_verify_out,
  input  logic [DES_BLK_W-1:0]       core_result_in,
  input  logic                       core_result_valid_in,
  input  logic                       core_err_in,
  output logic                       busy_out,
  output logic                       stray_out
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned TMR_W = $clog2(TIMEOUT);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [DES_BLK_W-1:0] data_q, data_d;
  logic [DES_KEY_W-1:0] key_q, key_d;
  logic               mode_q, mode_d;
  logic               verify_q, verify_d;
  logic [DES_BLK_W-1:0] rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               tmo_q, tmo_d;
  logic               stray_q, stray_d;
  logic [TMR_W-1:0]   timer_q, timer_d;

  logic [N_REQ-1:0]   gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               any_req;

  des_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req_i  (req_valid_in),
    .last_i (last_q),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx),
    .any_o  (any_req)
  );

  // Next-state, job latch, result capture and requester handshake.
  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    owner_d       = owner_q;
    data_d        = data_q;
    key_d         = key_q;
    mode_d        = mode_q;
    verify_d      = verify_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    tmo_d         = tmo_q;
    timer_d       = timer_q;
    req_ready_out = '0;
    // Core outputs arriving when no job is waiting are dropped and flagged.
    stray_d       = (core_result_valid_in | core_err_in) & (state_q != WAIT);
    case (state_q)
      IDLE: begin
        if (any_req) begin
          req_ready_out = gnt;
          owner_d       = gnt_idx;
          data_d        = req_data_in[32'(gnt_idx)*DES_BLK_W +: DES_BLK_W];
          key_d         = req_key_in[32'(gnt_idx)*DES_KEY_W +: DES_KEY_W];
          mode_d        = req_mode_in[gnt_idx];
          verify_d      = req_verify_in[gnt_idx];
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        if (core_ready_in) begin
          timer_d = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        if (core_err_in) begin
          rdata_d = '0;
          err_d   = 1'b1;
          tmo_d   = 1'b0;
          state_d = RESP;
        end else if (core_result_valid_in) begin
          rdata_d = core_result_in;
          err_d   = 1'b0;
          tmo_d   = 1'b0;
          state_d = RESP;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_in[owner_q]) begin
          last_d  = owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      last_q   <= IDX_W'(N_REQ - 1);
      owner_q  <= '0;
      data_q   <= '0;
      key_q    <= '0;
      mode_q   <= 1'b0;
      verify_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
      stray_q  <= 1'b0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      data_q   <= data_d;
      key_q    <= key_d;
      mode_q   <= mode_d;
      verify_q <= verify_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      stray_q  <= stray_d;
      timer_q  <= timer_d;
    end
  end

  // Response valid is steered to the owning requester only.
  always_comb begin
    rsp_valid_out = '0;
    if (state_q == RESP) rsp_valid_out[owner_q] = 1'b1;
  end

  assign core_valid_out  = (state_q == ISSUE);
  assign core_data_out   = data_q;
  assign core_key_out    = key_q;
  assign core_mode_out   = mode_q;
  assign core_verify_out = verify_q;
  assign rsp_data_out    = rdata_q;
  assign rsp_err_out     = err_q;
  assign rsp_timeout_out = tmo_q;
  assign busy_out        = (state_q != IDLE);
  assign stray_out       = stray_q;

endmodule
